// File: rtl/apb_memif_bridge.sv
// APB completer that turns each APB transfer into exactly one memory-interface request,
// with a bounded wait on the target acknowledge.
module apb_memif_bridge #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic                    mreq_o,
  output logic [ADDR_WIDTH-1:0]   maddr_o,
  output logic                    mwe_o,
  output logic [DATA_WIDTH-1:0]   mwdata_o,
  output logic [DATA_WIDTH/8-1:0] mstrb_o,
  input  logic                    mack_i,
  input  logic [DATA_WIDTH-1:0]   mrdata_i,
  input  logic                    mresp_i
);
  // state | meaning
  // IDLE  | waiting for psel_i, captures the APB request
  // REQ   | mreq_o high, waiting for mack_i or timeout
  // DONE  | pready_o high for one cycle with response held
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    mreq_q, mreq_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic                    mwe_q, mwe_d;
  logic [DATA_WIDTH-1:0]   mwdata_q, mwdata_d;
  logic [STRB_WIDTH-1:0]   mstrb_q, mstrb_d;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mreq_q    <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      maddr_q   <= '0;
      mwe_q     <= 1'b0;
      mwdata_q  <= '0;
      mstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mreq_q    <= mreq_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      maddr_q   <= maddr_d;
      mwe_q     <= mwe_d;
      mwdata_q  <= mwdata_d;
      mstrb_q   <= mstrb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    maddr_d   = maddr_q;
    mwe_d     = mwe_q;
    mwdata_d  = mwdata_q;
    mstrb_d   = mstrb_q;
    unique case (state_q)
      IDLE: begin
        // penable_i is deliberately ignored so the request launches in the setup phase
        if (psel_i) begin
          maddr_d  = paddr_i;
          mwe_d    = pwrite_i;
          mwdata_d = pwdata_i;
          mstrb_d  = pwrite_i ? pstrb_i : '0;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        // psel_i is not watched here: a started request always runs to ack or timeout
        if (mreq_q && mack_i) begin
          prdata_d  = mwe_q ? '0 : mrdata_i;
          pslverr_d = mresp_i;
          state_d   = DONE;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
          prdata_d  = '0;
          pslverr_d = 1'b1;
          state_d   = DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      DONE: begin
        prdata_d  = '0;
        pslverr_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mreq_d   = (state_d == REQ);
    pready_d = (state_d == DONE);
  end

  assign mreq_o    = mreq_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;
  assign maddr_o   = maddr_q;
  assign mwe_o     = mwe_q;
  assign mwdata_o  = mwdata_q;
  assign mstrb_o   = mstrb_q;
endmodule

// File: tb/tb_apb_memif_bridge.sv
// Self-checking bench for apb_memif_bridge: behavioural target memory with an RX pop register,
// plus a reference model of expected data, latency and request count per APB transfer.
module tb_apb_memif_bridge;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TMO = 16;
  localparam logic [AW-1:0] RX_ADDR = 5'h10;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic          psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [AW-1:0] paddr_i = '0;
  logic [DW-1:0] pwdata_i = '0;
  logic [SW-1:0] pstrb_i = '0;
  logic [DW-1:0] prdata_o;
  logic          pready_o, pslverr_o, mreq_o, mwe_o;
  logic [AW-1:0] maddr_o;
  logic [DW-1:0] mwdata_o;
  logic [SW-1:0] mstrb_o;
  logic          mack_i = 1'b0;
  logic [DW-1:0] mrdata_i = '0;
  logic          mresp_i = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  apb_memif_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .psel_i(psel_i), .penable_i(penable_i),
    .paddr_i(paddr_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .mreq_o(mreq_o), .maddr_o(maddr_o), .mwe_o(mwe_o), .mwdata_o(mwdata_o),
    .mstrb_o(mstrb_o), .mack_i(mack_i), .mrdata_i(mrdata_i), .mresp_i(mresp_i)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'hA000_0000 ^ (32'(a) * 32'h0101_0101);
  endfunction

  // Target knobs (written by the test process only)
  int   t_wait = 0;
  bit   t_ack_en = 1'b1;
  bit   t_err = 1'b0;
  logic [7:0] rx_data [16];

  // Target state (written by the responder only)
  logic [DW-1:0] tgt_mem [32];
  bit tgt_init = 1'b0;
  int wcnt = 0;
  int rx_pops = 0;

  always @(negedge clk_i) begin
    if (!tgt_init) begin
      for (int i = 0; i < 32; i++) tgt_mem[i] = init_val(i);
      tgt_init = 1'b1;
    end
    if (mreq_o === 1'b1) begin
      if (t_ack_en && wcnt == t_wait) begin
        mack_i  = 1'b1;
        mresp_i = t_err;
        if (mwe_o) begin
          for (int b = 0; b < SW; b++)
            if (mstrb_o[b]) tgt_mem[maddr_o][b*8 +: 8] = mwdata_o[b*8 +: 8];
          mrdata_i = $urandom;
        end else if (maddr_o == RX_ADDR) begin
          mrdata_i = {24'h0, rx_data[rx_pops % 16]};
          rx_pops++;
        end else begin
          mrdata_i = tgt_mem[maddr_o];
        end
      end else begin
        mack_i   = 1'b0;
        mrdata_i = $urandom;
        mresp_i  = 1'($urandom);
      end
      wcnt++;
    end else begin
      mack_i   = 1'b0;
      mrdata_i = $urandom;
      mresp_i  = 1'($urandom);
      wcnt     = 0;
    end
  end

  // Reference model: what the addressed word should hold
  logic [DW-1:0] ref_mem [32];

  function automatic bit times_out(input bit ack_en, input int w);
    return !ack_en || (w >= TMO);
  endfunction

  // Runs one APB transfer starting just after a rising edge; ends just after a rising edge.
  task automatic apb_xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                          input logic [SW-1:0] st, output logic [DW-1:0] rd, output logic er,
                          output int lat, output int nreq, output bit stable, output bit idle_ok);
    int idx;
    bit got;
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = a; pwrite_i = w; pwdata_i = wd; pstrb_i = st;
    idx = 0; got = 1'b0; nreq = 0; stable = 1'b1; idle_ok = 1'b1; lat = -1; rd = 'x; er = 1'bx;
    while (!got && idx < 64) begin
      @(negedge clk_i);
      if (idx == 0 && (pready_o !== 1'b0 || prdata_o !== '0 || pslverr_o !== 1'b0 || mreq_o !== 1'b0))
        idle_ok = 1'b0;
      if (mreq_o === 1'b1) begin
        nreq++;
        if (maddr_o !== a || mwe_o !== w || mwdata_o !== wd || mstrb_o !== (w ? st : '0))
          stable = 1'b0;
      end
      if (pready_o === 1'b1) begin
        got = 1'b1; lat = idx; rd = prdata_o; er = pslverr_o;
      end
      @(posedge clk_i); #1;
      if (idx == 0) penable_i = 1'b1;
      idx++;
    end
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  // Issues a transfer and checks everything against the reference model.
  task automatic do_check(input string nm, input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] wd, input logic [SW-1:0] st);
    logic [DW-1:0] rd, exp_rd;
    logic er, exp_er;
    int lat, nreq, exp_lat, exp_nreq;
    bit stable, idle_ok, tmo;
    tmo = times_out(t_ack_en, t_wait);
    exp_lat  = tmo ? TMO + 1 : t_wait + 2;
    exp_nreq = tmo ? TMO : t_wait + 1;
    exp_er   = tmo ? 1'b1 : t_err;
    exp_rd   = (tmo || w) ? '0 : ref_mem[a];
    if (w && !tmo)
      for (int b = 0; b < SW; b++) if (st[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
    apb_xfer(a, w, wd, st, rd, er, lat, nreq, stable, idle_ok);
    checks++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat);
    else passed++;
    checks++;
    if (nreq !== exp_nreq) $display("FAIL %s mreq_cycles: got %0d expected %0d", nm, nreq, exp_nreq);
    else passed++;
    checks++;
    if (rd !== exp_rd) $display("FAIL %s prdata: got %h expected %h", nm, rd, exp_rd);
    else passed++;
    checks++;
    if (er !== exp_er) $display("FAIL %s pslverr: got %b expected %b", nm, er, exp_er);
    else passed++;
    checks++;
    if (!stable) $display("FAIL %s mem_outputs: got unstable/wrong expected addr=%h we=%b", nm, a, w);
    else passed++;
    checks++;
    if (!idle_ok) $display("FAIL %s setup_idle: got busy outputs expected all clear", nm);
    else passed++;
  endtask

  task automatic test_reset();
    checks++;
    if ({mreq_o, maddr_o, mwe_o, mwdata_o, mstrb_o, prdata_o, pready_o, pslverr_o} !== '0)
      $display("FAIL reset_values: got mreq=%b maddr=%h prdata=%h pready=%b expected 0",
               mreq_o, maddr_o, prdata_o, pready_o);
    else passed++;
  endtask

  task automatic test_write_zero_wait();
    t_wait = 0; t_ack_en = 1'b1; t_err = 1'b0;
    do_check("wr_zero_wait", 5'h00, 1'b1, 32'h0000_00A5, 4'hF);
  endtask

  task automatic test_read_error();
    t_wait = 0; t_ack_en = 1'b1; t_err = 1'b0;
    do_check("wr_0x14", 5'h14, 1'b1, 32'h0000_003C, 4'hF);
    do_check("rd_ok", 5'h14, 1'b0, 32'hDEAD_BEEF, 4'hF);
    t_err = 1'b1;
    do_check("rd_err", 5'h14, 1'b0, 32'h1234_5678, 4'h3);
    t_err = 1'b0;
  endtask

  task automatic test_wait_states();
    t_ack_en = 1'b1; t_err = 1'b0;
    t_wait = 3;
    do_check("rd_wait3", 5'h03, 1'b0, 32'h0, 4'h0);
    do_check("wr_wait3", 5'h07, 1'b1, 32'h5A5A_1234, 4'h6);
    t_wait = 0;
  endtask

  task automatic test_timeout();
    t_ack_en = 1'b0; t_err = 1'b0;
    do_check("rd_timeout", 5'h02, 1'b0, 32'h0, 4'h0);
    do_check("wr_timeout", 5'h02, 1'b1, 32'hFFFF_FFFF, 4'hF);
    t_ack_en = 1'b1; t_wait = TMO - 1;
    do_check("rd_ack_last", 5'h02, 1'b0, 32'h0, 4'h0);
    t_wait = TMO;
    do_check("rd_ack_late", 5'h01, 1'b0, 32'h0, 4'h0);
    t_wait = 0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd0, rd1;
    logic er0, er1;
    int lat0, lat1, n0, n1, pops0;
    bit s0, s1, i0, i1;
    t_wait = 0; t_ack_en = 1'b1; t_err = 1'b0;
    pops0 = rx_pops;
    rx_data[pops0 % 16] = 8'($urandom);
    rx_data[(pops0 + 1) % 16] = 8'($urandom);
    apb_xfer(RX_ADDR, 1'b0, '0, '0, rd0, er0, lat0, n0, s0, i0);
    apb_xfer(RX_ADDR, 1'b0, '0, '0, rd1, er1, lat1, n1, s1, i1);
    checks++;
    if (rx_pops - pops0 !== 2) $display("FAIL b2b_pops: got %0d expected 2", rx_pops - pops0);
    else passed++;
    checks++;
    if (rd0 !== {24'h0, rx_data[pops0 % 16]})
      $display("FAIL b2b_byte0: got %h expected %h", rd0, rx_data[pops0 % 16]);
    else passed++;
    checks++;
    if (rd1 !== {24'h0, rx_data[(pops0 + 1) % 16]})
      $display("FAIL b2b_byte1: got %h expected %h", rd1, rx_data[(pops0 + 1) % 16]);
    else passed++;
    checks++;
    if (lat0 !== 2 || lat1 !== 2 || n0 !== 1 || n1 !== 1 || !i1)
      $display("FAIL b2b_timing: got lat=%0d/%0d nreq=%0d/%0d expected 2/2 1/1", lat0, lat1, n0, n1);
    else passed++;
    @(negedge clk_i);
    checks++;
    if (pready_o !== 1'b0 || prdata_o !== '0 || pslverr_o !== 1'b0)
      $display("FAIL pready_pulse: got pready=%b prdata=%h expected 0", pready_o, prdata_o);
    else passed++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 30; i++) begin
      do a = AW'($urandom); while (a == RX_ADDR);
      t_ack_en = ($urandom_range(0, 9) != 0);
      t_wait   = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
      t_err    = 1'($urandom);
      do_check("random", a, 1'($urandom), $urandom, SW'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    end
    t_ack_en = 1'b1; t_wait = 0; t_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    t_ack_en = 1'b0;
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 5'h09; pwrite_i = 1'b1;
    pwdata_i = 32'hCAFE_F00D; pstrb_i = 4'hF;
    @(posedge clk_i); #1 penable_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i);
    #3 arst_ni = 1'b0;
    #1;
    checks++;
    if ({mreq_o, maddr_o, mwe_o, mwdata_o, mstrb_o, prdata_o, pready_o, pslverr_o} !== '0)
      $display("FAIL reset_mid: got mreq=%b maddr=%h mwe=%b mwdata=%h expected 0",
               mreq_o, maddr_o, mwe_o, mwdata_o);
    else passed++;
    psel_i = 1'b0; penable_i = 1'b0;
    #2 arst_ni = 1'b1;
    @(posedge clk_i); #1;
    t_ack_en = 1'b1; t_wait = 1; t_err = 1'b0;
    do_check("rd_after_reset", 5'h09, 1'b0, 32'h0, 4'h0);
    t_wait = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < 16; i++) rx_data[i] = 8'h00;
    #12;
    test_reset();
    #10 arst_ni = 1'b1;
    @(posedge clk_i); #1;
    test_write_zero_wait();
    test_read_error();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/apb_memif_bridge.md
# apb_memif_bridge

APB completer that converts each APB transfer into exactly one request on the internal memory interface (`mreq/maddr/mwe/mwdata/mstrb` → `mack/mrdata/mresp`) used by `uart_regif`. It sits between the SoC APB fabric and the UART register block. It is the initiator side of that memory interface, and it guarantees one request per APB transfer, which side-effecting registers such as RX data pop depend on. It adds a bounded-wait timeout so a non-responding target cannot hang the bus.

## Interface
- `ADDR_WIDTH`, 5: address width on both APB and memory sides.
- `DATA_WIDTH`, 32: data width; must be a multiple of 8.
- `TIMEOUT_CYCLES`, 16: maximum cycles `mreq_o` waits for `mack_i`; 0 disables the timeout.

- `clk_i` in 1: single clock, rising edge.
- `arst_ni` in 1: asynchronous reset, active low.
- `psel_i` in 1: APB select.
- `penable_i` in 1: APB enable (access phase).
- `paddr_i` in ADDR_WIDTH: APB address.
- `pwrite_i` in 1: APB write (1) / read (0).
- `pwdata_i` in DATA_WIDTH: APB write data.
- `pstrb_i` in DATA_WIDTH/8: APB write strobes.
- `prdata_o` out DATA_WIDTH: APB read data.
- `pready_o` out 1: APB ready.
- `pslverr_o` out 1: APB error.
- `mreq_o` out 1: memory request.
- `maddr_o` out ADDR_WIDTH: memory address.
- `mwe_o` out 1: memory write enable.
- `mwdata_o` out DATA_WIDTH: memory write data.
- `mstrb_o` out DATA_WIDTH/8: memory byte strobes.
- `mack_i` in 1: memory acknowledge.
- `mrdata_i` in DATA_WIDTH: memory read data, valid in the ack cycle.
- `mresp_i` in 1: memory error, valid in the ack cycle.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- **IDLE**
  - On `psel_i=1` (`penable_i` ignored), register `paddr_i`, `pwrite_i` and `pwdata_i` into `maddr_o`, `mwe_o` and `mwdata_o`.
  - `mstrb_o` takes `pstrb_i` on writes and `'0` on reads.
  - Clear the timeout counter and go to REQ.
- **REQ**
  - `mreq_o=1` and all memory outputs are held stable.
  - Handshake completes in any cycle with `mreq_o & mack_i`. In that cycle:
    - reads latch `mrdata_i` into `prdata_o`; writes set `prdata_o='0`;
    - `pslverr_o` takes `mresp_i`;
    - FSM goes to DONE.
  - Each REQ cycle without ack increments the counter. With `TIMEOUT_CYCLES>0`, when the counter reaches `TIMEOUT_CYCLES-1` without ack, set `prdata_o='0` and `pslverr_o=1`, then go to DONE.
  - `mreq_o` deasserts on the DONE entry edge, so exactly one ack cycle is ever seen per transfer.
  - `psel_i` dropping during REQ is a protocol violation. The bridge still completes or times out the memory request; it never abandons it mid-flight.
- **DONE**
  - `pready_o=1`; `prdata_o` and `pslverr_o` are held.
  - Next edge returns to IDLE unconditionally.
  - `prdata_o` and `pslverr_o` clear to 0 on leaving DONE.
- Memory outputs other than `mreq_o` keep their last values outside REQ.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide (minimum 1) and saturates.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: `mreq_o=0`, `maddr_o=0`, `mwe_o=0`, `mwdata_o=0`, `mstrb_o=0`, `prdata_o=0`, `pready_o=0`, `pslverr_o=0`.
- Asserting `arst_ni` mid-transfer forces IDLE and all reset values immediately, with no completion.
- Zero-wait target (ack in the same cycle as `mreq_o`, as `uart_regif` behaves):
  - cycle 0: setup phase, IDLE samples `psel_i`;
  - cycle 1: REQ, `mreq_o=1`, ack;
  - cycle 2: DONE, `pready_o=1`.
  - This gives exactly one APB wait state.
- Target with N wait cycles: `pready_o` rises N cycles later.
- Timeout: `mreq_o` is high for exactly `TIMEOUT_CYCLES` cycles, and `pready_o` asserts on the following cycle.
- A new transfer may start in the cycle after DONE (back-to-back APB).
- `pready_o` is high for exactly one cycle per transfer.

## Test plan
- **Write, zero-wait.** APB write addr 0x00, data 0x0000_00A5, strb 0xF.
  - Memory side: one cycle with `mreq_o=1`, `mwe_o=1`, `maddr_o=0`, `mwdata_o=0xA5`, `mstrb_o=0xF`.
  - APB side: `pready_o` two cycles after setup, `pslverr_o=0`.
- **Read with error.** Read addr 0x14; target acks with `mrdata_i=0x3C`, `mresp_i=0`, then repeats with `mresp_i=1`.
  - First: `prdata_o=0x3C`, `pslverr_o=0`, `mstrb_o=0`.
  - Second: `pslverr_o=1`.
- **Wait states.** Target delays `mack_i` by 3 cycles.
  - `mreq_o` high for 4 cycles with stable address and data.
  - `pready_o` asserts in cycle 5 after setup.
- **Timeout.** `mack_i` tied low, `TIMEOUT_CYCLES=16`.
  - `mreq_o` high for exactly 16 cycles.
  - Then `pready_o=1`, `pslverr_o=1`, `prdata_o=0`.
- **Back-to-back reads, single request per transfer.** Two back-to-back reads of the RX data address against `uart_regif` holding 2 bytes.
  - Exactly 2 `rx_data_ready` pulses.
  - Bytes returned in order.
- **Reset mid-operation.** Assert `arst_ni` low during REQ with ack withheld.
  - All outputs at reset values immediately.
  - After release, a fresh read completes normally.
